// File: rtl/spi_tx_arbiter.sv
// Shares one SPI byte transmitter between a command requester (0) and a bulk requester (1).
// Handles round-robin grant, CS framing with bursts, the D/C pin and the bit-rate strobe.
module spi_tx_arbiter #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CS_SETUP  = 2,
    parameter int unsigned CS_IDLE   = 2,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       dc0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    input  logic       dc1,
    output logic       ack1,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       tx_clk_en,
    input  logic       tx_sent,
    output logic       cs_n,
    output logic       dc,
    output logic       busy
);

    // Handshake: a requester holds req/data/dc until its one-cycle ack; the
    // byte and D/C level are taken only in the START cycle.
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_START, S_WAIT, S_NEXT, S_RELEASE
    } state_e;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
    localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
    localparam logic [3:0] IDLE_LAST  = 4'(CS_IDLE - 1);

    state_e     state_q, state_d;
    logic       grant_q, grant_d;
    logic       ptr_q, ptr_d;
    logic [7:0] burst_q, burst_d;
    logic [7:0] div_q, div_d;
    logic [3:0] setup_q, setup_d;
    logic [3:0] idle_q, idle_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       dc_q, dc_d;

    logic       grant_req;
    logic       grant_dc;
    logic [7:0] grant_data;
    logic       arb_pick;

    assign grant_req  = grant_q ? req1  : req0;
    assign grant_dc   = grant_q ? dc1   : dc0;
    assign grant_data = grant_q ? data1 : data0;
    // With a lone request the pointer is irrelevant; req1 alone picks 1, req0 alone picks 0.
    assign arb_pick   = (req0 && req1) ? ptr_q : req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req0 || req1) state_d = S_SETUP;
            S_SETUP:   if (setup_q == SETUP_LAST) state_d = S_START;
            S_START:   state_d = S_WAIT;
            S_WAIT:    if (tx_sent) state_d = S_NEXT;
            S_NEXT:    state_d = (grant_req && (burst_q < BURST_MAX)) ? S_START : S_RELEASE;
            S_RELEASE: if (idle_q == IDLE_LAST) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cs_n      = (state_q == S_IDLE) || (state_q == S_RELEASE);
        tx_start  = (state_q == S_START);
        tx_data   = (state_q == S_START) ? grant_data : tx_data_q;
        dc        = (state_q == S_START) ? grant_dc   : dc_q;
        tx_clk_en = (state_q == S_WAIT) && (div_q == DIV_LAST);
        ack0      = (state_q == S_WAIT) && tx_sent && !grant_q;
        ack1      = (state_q == S_WAIT) && tx_sent && grant_q;
        busy      = (state_q != S_IDLE);
    end

    always_comb begin
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        burst_d   = burst_q;
        div_d     = div_q;
        setup_d   = setup_q;
        idle_d    = idle_q;
        tx_data_d = tx_data_q;
        dc_d      = dc_q;
        case (state_q)
            S_IDLE: begin
                setup_d = '0;
                if (req0 || req1) grant_d = arb_pick;
            end
            S_SETUP: setup_d = setup_q + 4'd1;
            S_START: begin
                tx_data_d = grant_data;
                dc_d      = grant_dc;
                div_d     = '0;
                burst_d   = burst_q + 8'd1;
            end
            S_WAIT: div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
            S_NEXT: begin
                idle_d = '0;
                if (!(grant_req && (burst_q < BURST_MAX))) begin
                    burst_d = '0;
                    ptr_d   = ~grant_q;
                end
            end
            S_RELEASE: idle_d = idle_q + 4'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q   <= 1'b0;
            ptr_q     <= 1'b0;
            burst_q   <= '0;
            div_q     <= '0;
            setup_q   <= '0;
            idle_q    <= '0;
            tx_data_q <= '0;
            dc_q      <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            burst_q   <= burst_d;
            div_q     <= div_d;
            setup_q   <= setup_d;
            idle_q    <= idle_d;
            tx_data_q <= tx_data_d;
            dc_q      <= dc_d;
        end
    end

    a_ack_onehot: assert property (@(posedge clk) disable iff (reset) !(ack0 && ack1));
    a_start_cs:   assert property (@(posedge clk) disable iff (reset) !(tx_start && cs_n));

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: a default instance plus a MAX_BURST=2 instance,
// each driven by a simple byte-transmitter model that counts eight bit strobes.
module tb_spi_tx_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0 = 1'b0, dc0 = 1'b0, req1 = 1'b0, dc1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic stray = 1'b0;
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic a_ack0, a_ack1, a_tx_start, a_tx_clk_en, a_tx_sent, a_cs_n, a_dc, a_busy;
    logic [7:0] a_tx_data;
    logic b_ack0, b_ack1, b_tx_start, b_tx_clk_en, b_tx_sent, b_cs_n, b_dc, b_busy;
    logic [7:0] b_tx_data;
    logic a_sent, a_inflight, b_sent, b_inflight;
    int a_bits, b_bits;

    assign a_tx_sent = a_sent | stray;
    assign b_tx_sent = b_sent;

    spi_tx_arbiter u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .dc0(dc0), .ack0(a_ack0),
        .req1(req1), .data1(data1), .dc1(dc1), .ack1(a_ack1),
        .tx_start(a_tx_start), .tx_data(a_tx_data), .tx_clk_en(a_tx_clk_en),
        .tx_sent(a_tx_sent), .cs_n(a_cs_n), .dc(a_dc), .busy(a_busy)
    );

    spi_tx_arbiter #(.MAX_BURST(2)) u_dut_mb (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .dc0(dc0), .ack0(b_ack0),
        .req1(req1), .data1(data1), .dc1(dc1), .ack1(b_ack1),
        .tx_start(b_tx_start), .tx_data(b_tx_data), .tx_clk_en(b_tx_clk_en),
        .tx_sent(b_tx_sent), .cs_n(b_cs_n), .dc(b_dc), .busy(b_busy)
    );

    // Transmitter models: sent pulses the cycle after the eighth strobe.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_inflight <= 1'b0; a_bits <= 0; a_sent <= 1'b0;
        end else begin
            a_sent <= 1'b0;
            if (a_tx_start) begin
                a_inflight <= 1'b1; a_bits <= 0;
            end else if (a_inflight && a_tx_clk_en) begin
                if (a_bits == 7) begin
                    a_inflight <= 1'b0; a_sent <= 1'b1;
                end
                a_bits <= a_bits + 1;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            b_inflight <= 1'b0; b_bits <= 0; b_sent <= 1'b0;
        end else begin
            b_sent <= 1'b0;
            if (b_tx_start) begin
                b_inflight <= 1'b1; b_bits <= 0;
            end else if (b_inflight && b_tx_clk_en) begin
                if (b_bits == 7) begin
                    b_inflight <= 1'b0; b_sent <= 1'b1;
                end
                b_bits <= b_bits + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0; data0 = '0; data1 = '0; dc0 = 0; dc1 = 0; stray = 0;
        reset = 1; tick(); tick();
        reset = 0; tick();
    endtask

    initial begin
        int t, t_cs, t_en, acks, starts, falls, len, t_rise, idx, foreign, both, cur_owner;
        logic prev_cs;
        logic [7:0] bytes3[3];
        logic       dcs3[3];
        int owners[$];

        // Reset state
        tick();
        check_eq("rst_cs_n", a_cs_n, 1);
        check_eq("rst_dc", a_dc, 0);
        check_eq("rst_tx_start", a_tx_start, 0);
        check_eq("rst_tx_data", a_tx_data, 0);
        check_eq("rst_clk_en", a_tx_clk_en, 0);
        check_eq("rst_acks", {a_ack0, a_ack1}, 0);
        check_eq("rst_busy", a_busy, 0);

        // Single byte
        do_reset();
        req0 = 1; data0 = 8'hA5; dc0 = 0;
        t = 0; while (a_cs_n && t < 20) begin tick(); t++; end
        check_eq("t1_cs_fall", a_cs_n, 0);
        t_cs = cyc;
        t = 0; while (!a_tx_start && t < 20) begin tick(); t++; end
        check_eq("t1_start_seen", a_tx_start, 1);
        check_eq("t1_start_delay", cyc - t_cs, 2);
        check_eq("t1_tx_data", a_tx_data, 8'hA5);
        check_eq("t1_dc", a_dc, 0);
        t = 0; while (!a_tx_clk_en && t < 20) begin tick(); t++; end
        t_en = cyc;
        tick();
        t = 0; while (!a_tx_clk_en && t < 20) begin tick(); t++; end
        check_eq("t1_clk_en_period", cyc - t_en, 4);
        t = 0; while (!a_ack0 && t < 400) begin tick(); t++; end
        check_eq("t1_ack0", a_ack0, 1);
        check_eq("t1_ack_in_sent", a_tx_sent, 1);
        check_eq("t1_no_ack1", a_ack1, 0);
        req0 = 0;
        tick();
        tick();
        check_eq("t1_cs_rise", a_cs_n, 1);
        tick();
        check_eq("t1_cs_high2", a_cs_n, 1);
        tick();
        check_eq("t1_cs_high3", a_cs_n, 1);
        check_eq("t1_idle_busy", a_busy, 0);

        // Burst of three bytes on requester 1, D/C changing per byte
        do_reset();
        bytes3[0] = 8'h01; bytes3[1] = 8'h02; bytes3[2] = 8'h03;
        dcs3[0] = 1'b1; dcs3[1] = 1'b0; dcs3[2] = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back({dcs3[i], bytes3[i]});
        idx = 0; acks = 0; starts = 0; falls = 0; foreign = 0; prev_cs = 1;
        req1 = 1; data1 = bytes3[0]; dc1 = dcs3[0];
        for (int i = 0; i < 600 && acks < 3; i++) begin
            tick();
            if (prev_cs && !a_cs_n) falls++;
            prev_cs = a_cs_n;
            if (a_tx_start) begin
                starts++;
                if (exp_q.size() > 0) check_eq("t2_byte", {a_dc, a_tx_data}, exp_q.pop_front());
                else check_eq("t2_extra_start", 1, 0);
            end
            if (a_ack0) foreign++;
            if (a_ack1) begin
                acks++; idx++;
                if (idx < 3) begin data1 = bytes3[idx]; dc1 = dcs3[idx]; end
                else req1 = 0;
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (prev_cs && !a_cs_n) falls++;
            prev_cs = a_cs_n;
        end
        check_eq("t2_starts", starts, 3);
        check_eq("t2_acks", acks, 3);
        check_eq("t2_cs_windows", falls, 1);
        check_eq("t2_no_ack0", foreign, 0);

        // MAX_BURST=2 instance with five bytes on requester 0
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, 8'(8'h10 + i)});
        idx = 0; acks = 0; falls = 0; prev_cs = 1; t_rise = 0;
        req0 = 1; data0 = 8'h10; dc0 = 1;
        for (int i = 0; i < 1200 && acks < 5; i++) begin
            tick();
            if (!prev_cs && b_cs_n) t_rise = cyc;
            if (prev_cs && !b_cs_n) begin
                falls++;
                if (falls > 1) begin
                    len = cyc - t_rise;
                    check_eq("t3_idle_gap", len >= 2, 1);
                end
            end
            prev_cs = b_cs_n;
            if (b_tx_start) begin
                if (exp_q.size() > 0) check_eq("t3_byte", {b_dc, b_tx_data}, exp_q.pop_front());
                else check_eq("t3_extra_start", 1, 0);
            end
            if (b_ack0) begin
                acks++; idx++;
                if (idx < 5) data0 = 8'(8'h10 + idx);
                else req0 = 0;
            end
        end
        check_eq("t3_acks", acks, 5);
        check_eq("t3_cs_frames", falls, 3);

        // Contention from reset: frames alternate 0,1,0,1
        do_reset();
        owners.delete();
        both = 0; foreign = 0; cur_owner = -1; prev_cs = 1;
        req0 = 1; data0 = 8'h3C; dc0 = 0;
        req1 = 1; data1 = 8'hC3; dc1 = 1;
        for (int i = 0; i < 4000 && owners.size() < 4; i++) begin
            tick();
            if (prev_cs && !a_cs_n) cur_owner = -1;
            prev_cs = a_cs_n;
            if (a_ack0 && a_ack1) both++;
            if (a_ack0 || a_ack1) begin
                if (cur_owner < 0) begin
                    cur_owner = a_ack1 ? 1 : 0;
                    owners.push_back(cur_owner);
                end else if ((a_ack1 ? 1 : 0) != cur_owner) begin
                    foreign++;
                end
            end
        end
        check_eq("t4_frames", owners.size(), 4);
        for (int i = 0; i < 4; i++)
            check_eq("t4_owner", (i < owners.size()) ? owners[i] : 9, i % 2);
        check_eq("t4_ack_overlap", both, 0);
        check_eq("t4_foreign_ack", foreign, 0);
        req0 = 0; req1 = 0;

        // Reset during WAIT, then a clean frame from requester 1
        do_reset();
        req0 = 1; data0 = 8'h55; dc0 = 0;
        t = 0; while (!a_tx_clk_en && t < 60) begin tick(); t++; end
        check_eq("t5_in_wait", a_tx_clk_en, 1);
        reset = 1;
        #1;
        check_eq("t5_cs_n", a_cs_n, 1);
        check_eq("t5_busy", a_busy, 0);
        check_eq("t5_no_ack", {a_ack0, a_ack1}, 0);
        tick();
        reset = 0; req0 = 0;
        req1 = 1; data1 = 8'h77; dc1 = 1;
        t = 0; while (a_cs_n && t < 20) begin tick(); t++; end
        check_eq("t5_cs_fall", a_cs_n, 0);
        t_cs = cyc;
        t = 0; while (!a_tx_start && t < 20) begin tick(); t++; end
        check_eq("t5_start_delay", cyc - t_cs, 2);
        check_eq("t5_byte", {a_dc, a_tx_data}, {1'b1, 8'h77});
        t = 0; while (!a_ack1 && t < 400) begin tick(); t++; end
        check_eq("t5_ack1", a_ack1, 1);
        req1 = 0;

        // Stray tx_sent in IDLE
        do_reset();
        tick();
        stray = 1;
        #1;
        check_eq("t6_no_ack", {a_ack0, a_ack1}, 0);
        tick();
        stray = 0;
        check_eq("t6_busy", a_busy, 0);
        check_eq("t6_cs_n", a_cs_n, 1);
        tick();
        check_eq("t6_still_idle", a_busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
